// File: rtl/lcd_pkg.sv
// Shared types and derived constants for the EZDim LED driver.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_START    = 3'd1,
        ST_IDLE     = 3'd2,
        ST_PULSE_LO = 3'd3,
        ST_PULSE_HI = 3'd4,
        ST_SHDN     = 3'd5
    } lcd_state_e;

    // Clock cycles per microsecond; never below one so the prescaler stays legal.
    function automatic int unsigned us_div(input int unsigned clk_hz);
        return (clk_hz < 32'd1000000) ? 32'd1 : clk_hz / 32'd1000000;
    endfunction

    // Number of brightness steps the device supports.
    function automatic int unsigned n_steps(input int unsigned level_w);
        return 32'd1 << level_w;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// One-cycle tick every microsecond, derived from the system clock.
module us_tick_gen
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ = 0
) (
    input  logic clk,
    input  logic srst,
    output logic tick
);

    localparam int unsigned US_DIV = us_div(CLK_HZ);
    localparam int unsigned CNT_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_W'(US_DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/lcd_ezdim_driver.sv
// EZDim 1-wire brightness driver: walks the LED driver's level counter down with
// low pulses until it matches the requested level; a long low hold shuts it off.
module lcd_ezdim_driver
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 0,
    parameter int unsigned LEVEL_W    = 5,
    parameter int unsigned T_PULSE_US = 10,
    parameter int unsigned T_START_US = 100,
    parameter int unsigned T_SHDN_US  = 2500
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [LEVEL_W-1:0] level,
    output logic               pulse_out,
    output logic               busy,
    output logic               done,
    output logic [LEVEL_W-1:0] cur_level
);

    localparam int unsigned N     = n_steps(LEVEL_W);
    localparam int unsigned T_PS  = (T_PULSE_US > T_START_US) ? T_PULSE_US : T_START_US;
    localparam int unsigned T_MAX = (T_SHDN_US > T_PS) ? T_SHDN_US : T_PS;
    localparam int unsigned TMR_W = $clog2(T_MAX + 1);

    logic               us_tick;
    lcd_state_e         state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TMR_W-1:0]   t_lim_c;
    logic               t_end_c;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic [LEVEL_W-1:0] steps_q, steps_d;
    logic [LEVEL_W-1:0] pos_q, pos_d;
    logic [LEVEL_W-1:0] cur_q, cur_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    us_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk  (clk),
        .srst (srst),
        .tick (us_tick)
    );

    // Last tick of the timed phase the FSM is currently in.
    always_comb begin
        t_lim_c = '0;
        unique case (state_q)
            ST_START:    t_lim_c = TMR_W'(T_START_US - 1);
            ST_PULSE_LO,
            ST_PULSE_HI: t_lim_c = TMR_W'(T_PULSE_US - 1);
            ST_SHDN:     t_lim_c = TMR_W'(T_SHDN_US - 1);
            default:     t_lim_c = '0;
        endcase
        t_end_c = us_tick && (timer_q == t_lim_c);
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        target_d = target_q;
        steps_d  = steps_q;
        pos_d    = pos_q;
        cur_d    = cur_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                if (us_tick && (level != '0)) begin
                    target_d = level;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (t_end_c) begin
                    steps_d = LEVEL_W'(N - 1) - target_q;
                    pos_d   = LEVEL_W'(N - 1);
                    state_d = ST_PULSE_LO;
                end else if (us_tick) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_IDLE: begin
                if (us_tick) begin
                    if (level == '0) begin
                        state_d = ST_SHDN;
                    end else if (level != cur_q) begin
                        // Device only counts down, so going up wraps through N-1.
                        target_d = level;
                        steps_d  = cur_q - level;
                        state_d  = ST_PULSE_LO;
                    end
                end
            end
            ST_PULSE_LO: begin
                if (steps_q == '0) begin
                    cur_d   = target_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (t_end_c) begin
                    state_d = ST_PULSE_HI;
                end else if (us_tick) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_PULSE_HI: begin
                if (t_end_c) begin
                    steps_d = steps_q - LEVEL_W'(1);
                    pos_d   = pos_q - LEVEL_W'(1);
                    state_d = ST_PULSE_LO;
                end else if (us_tick) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SHDN: begin
                if (t_end_c) begin
                    cur_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_OFF;
                end else if (us_tick) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ST_OFF;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end

        // Outputs follow the state being entered so they register in step with it.
        pulse_d = !((state_d == ST_OFF) || (state_d == ST_SHDN) ||
                    ((state_d == ST_PULSE_LO) && (steps_d != '0)));
        busy_d  = (state_d == ST_START) || (state_d == ST_PULSE_HI) || (state_d == ST_SHDN) ||
                  ((state_d == ST_PULSE_LO) && (steps_d != '0));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= ST_OFF;
            timer_q  <= '0;
            target_q <= '0;
            steps_q  <= '0;
            pos_q    <= '0;
            cur_q    <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            target_q <= target_d;
            steps_q  <= steps_d;
            pos_q    <= pos_d;
            cur_q    <= cur_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cur_level = cur_q;

endmodule

// File: tb/tb_lcd_ezdim_driver.sv
// Self-checking bench for lcd_ezdim_driver at 10 MHz with default timing.
module tb_lcd_ezdim_driver;

    localparam int NLEV = 32;
    localparam int DIV  = 10;
    localparam int TP   = 10;
    localparam int TS   = 100;
    localparam int TSD  = 2500;

    logic       clk = 1'b0;
    logic       srst;
    logic [4:0] level;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [4:0] cur_level;

    always #5 clk = ~clk;

    lcd_ezdim_driver #(
        .CLK_HZ     (10_000_000),
        .LEVEL_W    (5),
        .T_PULSE_US (TP),
        .T_START_US (TS),
        .T_SHDN_US  (TSD)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .level     (level),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .cur_level (cur_level)
    );

    typedef struct packed {
        logic       p;
        logic       b;
        logic       d;
        logic [4:0] c;
    } exp_t;

    exp_t mq[$];
    int   cyc      = 0;
    int   rel      = 0;
    int   phase    = 0;
    bit   phase_ok = 1'b0;
    bit   cmp_en   = 1'b0;
    int   m_cur    = 0;
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   nfall    = 0;
    int   ndone    = 0;
    int   fall_e   = 0;
    int   done_e   = 0;
    logic prev_p   = 1'b0;

    function automatic bit is_tick(input int e);
        return ((e - rel) % DIV) == phase;
    endfunction

    task automatic push(input logic p, input logic b, input logic d, input int c, input int n);
        exp_t e;
        e.p = p;
        e.b = b;
        e.d = d;
        e.c = 5'(c);
        repeat (n) mq.push_back(e);
    endtask

    // Expected line/busy/done/cur trace of a whole sequence accepted at this edge.
    task automatic plan(input int lvl);
        int k;
        if (lvl == 0) begin
            push(1'b0, 1'b1, 1'b0, m_cur, DIV * TSD);
            push(1'b0, 1'b0, 1'b1, 0, 1);
        end else begin
            if (m_cur == 0) begin
                push(1'b1, 1'b1, 1'b0, 0, DIV * TS);
                k = NLEV - 1 - lvl;
            end else begin
                k = (m_cur - lvl + NLEV) % NLEV;
            end
            for (int i = 0; i < k; i++) begin
                push(1'b0, 1'b1, 1'b0, m_cur, DIV * TP);
                push(1'b1, 1'b1, 1'b0, m_cur, DIV * TP);
            end
            push(1'b1, 1'b0, 1'b0, m_cur, 1);
            push(1'b1, 1'b0, 1'b1, lvl, 1);
        end
        m_cur = lvl;
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic wait_pulse(input logic v, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pulse_out === v) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_pulse: pulse_out never reached %b within %0d cycles", v, budget);
        end
    endtask

    task automatic settle(input int budget);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        repeat (DIV + 2) @(negedge clk);
        while (quiet < 20 && n < budget) begin
            @(negedge clk);
            n++;
            quiet = (mq.size() == 0) ? quiet + 1 : 0;
        end
        if (quiet < 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL settle: sequence still running after %0d cycles", budget);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int s;
        int t1;
        int t2;
        int t3;
        int f0;
        int d0;
        srst  = 1'b1;
        level = 5'd0;

        fork
            forever begin : model_loop
                exp_t e;
                @(posedge clk);
                cyc++;
                if (srst) begin
                    mq.delete();
                    m_cur = 0;
                    rel   = cyc + 1;
                end else if (phase_ok && mq.size() == 0 && is_tick(cyc)) begin
                    if ((m_cur == 0 && level != 5'd0) || (m_cur != 0 && int'(level) != m_cur))
                        plan(int'(level));
                end
                @(negedge clk);
                if (prev_p && !pulse_out) begin
                    fall_e = cyc;
                    nfall++;
                end
                if (done) begin
                    ndone++;
                    done_e = cyc;
                end
                prev_p = pulse_out;
                if (mq.size() > 0) e = mq.pop_front();
                else e = '{p: (m_cur != 0), b: 1'b0, d: 1'b0, c: 5'(m_cur)};
                if (cmp_en) begin
                    n_cmp++;
                    if (pulse_out !== e.p || busy !== e.b || done !== e.d || cur_level !== e.c) begin
                        n_err++;
                        $display("FAIL cycle %0d: pulse/busy/done/cur got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                                 cyc, pulse_out, busy, done, cur_level, e.p, e.b, e.d, e.c);
                    end
                end
            end
        join_none

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_pulse", int'(pulse_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_cur", int'(cur_level), 0);
        @(posedge clk);
        #2;
        srst   = 1'b0;
        cmp_en = 1'b1;

        // Level 0 out of reset: line must stay quiet.
        repeat (5000) @(posedge clk);
        #2;
        check("off_cur", int'(cur_level), 0);

        // Learn the microsecond tick alignment from the first accepted request.
        cmp_en = 1'b0;
        s      = cyc;
        level  = 5'd31;
        wait_pulse(1'b1, 40, t1);
        check("start_latency_ok", int'((t1 - s) >= 1 && (t1 - s) <= DIV + 1), 1);
        phase = (t1 - rel) % DIV;

        // Abort in START: line low one edge later, no done.
        repeat (200) @(posedge clk);
        #2;
        srst  = 1'b1;
        level = 5'd0;
        @(posedge clk);
        @(negedge clk);
        check("abort_start_pulse", int'(pulse_out), 0);
        check("abort_start_busy", int'(busy), 0);
        check("abort_start_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #2;
        srst     = 1'b0;
        phase_ok = 1'b1;
        cmp_en   = 1'b1;

        // 0 -> 20: 100 us start, then 11 pulses.
        repeat (50) @(posedge clk);
        #2;
        f0    = nfall;
        d0    = ndone;
        level = 5'd20;
        wait_pulse(1'b1, 40, t1);
        wait_pulse(1'b0, 1200, t2);
        wait_pulse(1'b1, 200, t3);
        check("start_high_cycles", t2 - t1, 1000);
        check("pulse_low_cycles", t3 - t2, 100);
        settle(6000);
        check("up20_pulses", nfall - f0, 11);
        check("up20_done", ndone - d0, 1);
        check("up20_cur", int'(cur_level), 20);

        // 20 -> 25 wraps through the top.
        f0    = nfall;
        d0    = ndone;
        level = 5'd25;
        settle(8000);
        check("wrap25_pulses", nfall - f0, 27);
        check("wrap25_done", ndone - d0, 1);
        check("wrap25_cur", int'(cur_level), 25);

        // 25 -> 10, changed to 5 mid-sequence: newest value applied afterwards.
        f0    = nfall;
        d0    = ndone;
        level = 5'd10;
        for (int i = 0; i < 30 && mq.size() == 0; i++) @(negedge clk);
        repeat (100) @(posedge clk);
        #2;
        level = 5'd5;
        settle(10000);
        check("chain_pulses", nfall - f0, 20);
        check("chain_done", ndone - d0, 2);
        check("chain_cur", int'(cur_level), 5);

        // 5 -> 0: shutdown hold.
        d0    = ndone;
        level = 5'd0;
        settle(30000);
        check("shdn_low_cycles", done_e - fall_e, 25000);
        check("shdn_done", ndone - d0, 1);
        check("shdn_cur", int'(cur_level), 0);
        check("shdn_pulse", int'(pulse_out), 0);

        // 0 -> 31: start only, no pulses.
        f0    = nfall;
        d0    = ndone;
        level = 5'd31;
        settle(3000);
        check("max_pulses", nfall - f0, 0);
        check("max_done", ndone - d0, 1);
        check("max_cur", int'(cur_level), 31);
        check("max_pulse", int'(pulse_out), 1);

        // 31 -> 1, reset in the middle of a high half-pulse.
        level = 5'd1;
        wait_pulse(1'b0, 40, t1);
        repeat (150) @(posedge clk);
        #2;
        d0   = ndone;
        srst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_hi_pulse", int'(pulse_out), 0);
        check("abort_hi_busy", int'(busy), 0);
        check("abort_hi_cur", int'(cur_level), 0);
        check("abort_hi_done", int'(done), 0);
        repeat (20) @(posedge clk);
        #2;
        check("abort_hi_no_done", ndone - d0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_ezdim_driver.md
LCD_EZDIM_DRIVER -- requirements
Module: lcd_ezdim_driver

Interface
REQ-001 Parameter CLK_HZ, default 0; system clock frequency in Hz, must be a multiple of 1000000 and at least 1000000.
REQ-002 Parameter LEVEL_W, default 5; level width; the device has N = 2^LEVEL_W steps.
REQ-003 Parameter T_PULSE_US, default 10; duration of each low and each high half-pulse, in us.
REQ-004 Parameter T_START_US, default 100; high time after enable before the first pulse, in us.
REQ-005 Parameter T_SHDN_US, default 2500; low hold time that forces device shutdown, in us.
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 srst  in  1  reset, synchronous, active-high.
REQ-008 level  in  LEVEL_W  requested brightness; 0 = off, N-1 = maximum.
REQ-009 pulse_out  out  1  EZDim 1-wire line to the LED driver.
REQ-010 busy  out  1  high while a start, pulse or shutdown sequence is in progress.
REQ-011 done  out  1  one-cycle strobe when a sequence completes and the line settles.
REQ-012 cur_level  out  LEVEL_W  level the device currently holds (0 when off).

Function
REQ-013 A 1 us tick shall be derived from clk by a prescaler of CLK_HZ/1000000 cycles; all timing shall be counted in ticks.
REQ-014 States: OFF, START, IDLE, PULSE_LO, PULSE_HI, SHDN.
REQ-015 OFF: pulse_out=0 and busy=0. If level!=0, the block shall latch target=level, set pulse_out=1, and go to START.
REQ-016 START: after T_START_US ticks, the block shall load steps=(N-1)-target, set pos=N-1, and go to PULSE_LO.
REQ-017 IDLE: pulse_out=1. If level!=cur_level and level!=0, the block shall latch target=level, compute steps=(cur_level-level) mod N in LEVEL_W bits, and go to PULSE_LO. If level==0, it shall go to SHDN.
REQ-018 PULSE_LO: if steps==0, pulse_out=1, cur_level=target, done pulses, go to IDLE. Otherwise pulse_out=0 for T_PULSE_US ticks, then go to PULSE_HI.
REQ-019 PULSE_HI: pulse_out=1 for T_PULSE_US ticks. Then steps decrements by 1, pos decrements modulo N (0 wraps to N-1), and the state returns to PULSE_LO.
REQ-020 SHDN: pulse_out=0 for T_SHDN_US ticks, then cur_level=0, done pulses, go to OFF.
REQ-021 Level changes during START, PULSE_LO, PULSE_HI or SHDN shall be ignored until the sequence completes. The block shall then re-evaluate level in IDLE/OFF on the next tick, so the newest value wins.
REQ-022 busy shall be 1 in START, PULSE_LO (steps!=0), PULSE_HI and SHDN; otherwise 0.
REQ-023 The step count shall use LEVEL_W-bit unsigned wrap arithmetic; cur_level==level shall produce no pulses.
REQ-024 Decisions in OFF/IDLE shall be taken only on tick cycles; latency from a level change to the first falling edge shall be at most 1 us plus 1 clk.
REQ-025 Timing counters shall be wide enough for T_SHDN_US at minimum; overflow is prohibited.

Reset
REQ-026 On srst: state=OFF, pulse_out=0, busy=0, done=0, cur_level=0, steps=0, prescaler and timers cleared.
REQ-027 srst asserted mid-sequence shall abort on the next edge; the line shall go low immediately, with no completion strobe.

Structure
REQ-028 State encoding, and the derived constants US_DIV and N, shall live in shared package lcd_pkg.
REQ-029 The 1 us prescaler shall be sub-module us_tick_gen (param CLK_HZ; ports clk, srst, tick).
REQ-030 pulse_out, busy and done shall be registered outputs.

Verification (CLK_HZ=10000000, LEVEL_W=5, defaults)
REQ-031 Reset, level=0 -> pulse_out stays 0, busy=0, cur_level=0 for 5000 cycles.
REQ-032 level 0->20 -> pulse_out high 1000 cycles, then 11 low pulses each 100 cycles low/100 high; done once; cur_level=20.
REQ-033 From 20, level=25 -> 27 pulses (wrap: (20-25) mod 32); cur_level=25.
REQ-034 From 25, level=10 at 10 us into the sequence, then level=5 -> the first sequence completes at 10. The second runs 5 pulses; final cur_level=5.
REQ-035 From 5, level=0 -> line low 25000 cycles, done strobe, state OFF; level=31 afterwards -> START then 0 pulses, cur_level=31.
REQ-036 srst during PULSE_HI -> next cycle pulse_out=0, busy=0, cur_level=0, no done.
